// File: rtl/ppu_pkg.sv
// Shared PPU definitions: VRAM/palette geometry, the register-interface command
// record and the arbiter FSM encoding.
package ppu_pkg;

    localparam logic [5:0] PALETTE_BASE_HI = 6'h3F;
    localparam int         VRAM_AW         = 14;
    localparam int         DATA_W          = 8;
    localparam int         PAL_AW          = 5;
    localparam int         PAL_DW          = 6;

    typedef struct packed {
        logic               wr;
        logic [VRAM_AW-1:0] a;
        logic [DATA_W-1:0]  wdata;
    } ri_cmd_t;

    localparam int CMD_W = $bits(ri_cmd_t);

    typedef enum logic {
        ST_IDLE,
        ST_RD_WAIT
    } arb_state_t;

    // Sprite-palette backdrop entries (0x10/14/18/1C) alias the background ones.
    function automatic logic [PAL_AW-1:0] pal_index(input logic [PAL_AW-1:0] low);
        if (low[4] && (low[1:0] == 2'b00)) begin
            return low & 5'h0F;
        end
        return low;
    endfunction

endpackage

// File: rtl/ppu_ri_fifo.sv
// Parameterised synchronous FIFO with first-word-fall-through head, full,
// empty and occupancy count.
module ppu_ri_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // NOTE: storage carries no reset; only the pointers define what is valid,
    // which keeps the array a plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/ppu_vram_arb.sv
// VRAM/palette bus arbiter: display fetch has absolute priority, queued
// register-interface commands use the idle cycles.
module ppu_vram_arb
    import ppu_pkg::*;
#(
    parameter int         QDEPTH     = 4,
    parameter logic [5:0] STARVE_MAX = 6'd32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               disp_req,
    input  logic [VRAM_AW-1:0] disp_a,
    input  logic               ri_valid,
    input  logic               ri_wr,
    input  logic [VRAM_AW-1:0] ri_a,
    input  logic [DATA_W-1:0]  ri_wdata,
    output logic               ri_ready,
    output logic               ri_rvalid,
    output logic [DATA_W-1:0]  ri_rdata,
    output logic [VRAM_AW-1:0] vram_a,
    output logic [DATA_W-1:0]  vram_dout,
    output logic               vram_wr,
    input  logic [DATA_W-1:0]  vram_din,
    output logic [PAL_AW-1:0]  pal_a,
    output logic               pal_wr,
    output logic [PAL_DW-1:0]  pal_dout,
    input  logic [PAL_DW-1:0]  pal_din,
    output logic               ri_starved
);

    localparam int QCW = $clog2(QDEPTH) + 1;

    arb_state_t        state_q, state_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rvalid_q, rvalid_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic [5:0]        starve_q, starve_d;
    logic              starved_q, starved_d;
    logic              ready_q;

    logic [CMD_W-1:0]  q_rdata;
    logic              q_full;
    logic              q_empty;
    logic [QCW-1:0]    q_count;
    ri_cmd_t           head;
    logic              head_is_pal;
    logic              can_issue;

    ppu_ri_fifo #(
        .DEPTH (QDEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (ri_valid && ri_ready),
        .wdata_i ({ri_wr, ri_a, ri_wdata}),
        .pop_i   (can_issue),
        .rdata_o (q_rdata),
        .full_o  (q_full),
        .empty_o (q_empty),
        .count_o (q_count)
    );

    assign head        = ri_cmd_t'(q_rdata);
    assign head_is_pal = (head.a[13:8] == PALETTE_BASE_HI);
    assign can_issue   = !q_empty && !disp_req && (state_q == ST_IDLE);

    assign ri_ready   = ready_q && !q_full;
    assign ri_rvalid  = rvalid_q;
    assign ri_rdata   = rdata_q;
    assign ri_starved = starved_q;
    assign pal_a      = pal_index(head.a[4:0]);
    assign pal_dout   = head.wdata[PAL_DW-1:0];

    // NOTE: every signal driven here gets its default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        rdata_d   = rdata_q;
        rvalid_d  = 1'b0;
        dout_d    = dout_q;
        vram_a    = disp_a;
        vram_dout = dout_q;
        vram_wr   = 1'b0;
        pal_wr    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (can_issue) begin
                    vram_a = head.a;
                    if (head_is_pal) begin
                        if (head.wr) begin
                            pal_wr = 1'b1;
                        end else begin
                            rdata_d  = {2'b00, pal_din};
                            rvalid_d = 1'b1;
                        end
                    end else if (head.wr) begin
                        vram_wr   = 1'b1;
                        vram_dout = head.wdata;
                        dout_d    = head.wdata;
                    end else begin
                        state_d = ST_RD_WAIT;
                    end
                end
            end
            ST_RD_WAIT: begin
                // Synchronous VRAM presents data one cycle after the address.
                state_d  = ST_IDLE;
                rdata_d  = vram_din;
                rvalid_d = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        starve_d = starve_q;
        if (can_issue) begin
            starve_d = '0;
        end else if (disp_req && (q_count != '0) && (starve_q != STARVE_MAX)) begin
            starve_d = starve_q + 6'd1;
        end
        starved_d = starved_q || (starve_d == STARVE_MAX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
            dout_q    <= '0;
            starve_q  <= '0;
            starved_q <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            rdata_q   <= rdata_d;
            rvalid_q  <= rvalid_d;
            dout_q    <= dout_d;
            starve_q  <= starve_d;
            starved_q <= starved_d;
            ready_q   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ppu_vram_arb.sv
// Directed bench for ppu_vram_arb with a synchronous VRAM and combinational
// palette RAM model.
module tb_ppu_vram_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        disp_req;
    logic [13:0] disp_a;
    logic        ri_valid;
    logic        ri_wr;
    logic [13:0] ri_a;
    logic [7:0]  ri_wdata;
    logic        ri_ready;
    logic        ri_rvalid;
    logic [7:0]  ri_rdata;
    logic [13:0] vram_a;
    logic [7:0]  vram_dout;
    logic        vram_wr;
    logic [7:0]  vram_din;
    logic [4:0]  pal_a;
    logic        pal_wr;
    logic [5:0]  pal_dout;
    logic [5:0]  pal_din;
    logic        ri_starved;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] vram_mem [0:16383];
    logic [5:0] pal_mem  [0:31];

    ppu_vram_arb dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .disp_req   (disp_req),
        .disp_a     (disp_a),
        .ri_valid   (ri_valid),
        .ri_wr      (ri_wr),
        .ri_a       (ri_a),
        .ri_wdata   (ri_wdata),
        .ri_ready   (ri_ready),
        .ri_rvalid  (ri_rvalid),
        .ri_rdata   (ri_rdata),
        .vram_a     (vram_a),
        .vram_dout  (vram_dout),
        .vram_wr    (vram_wr),
        .vram_din   (vram_din),
        .pal_a      (pal_a),
        .pal_wr     (pal_wr),
        .pal_dout   (pal_dout),
        .pal_din    (pal_din),
        .ri_starved (ri_starved)
    );

    always #10 clk = ~clk;

    always @(posedge clk) begin
        if (vram_wr) vram_mem[vram_a] <= vram_dout;
        vram_din <= vram_mem[vram_a];
    end

    assign pal_din = pal_mem[pal_a];
    always @(posedge clk) begin
        if (pal_wr) pal_mem[pal_a] <= pal_dout;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run did not complete within time limit");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; disp_req = 1'b0; disp_a = 14'h0123;
        ri_valid = 1'b0; ri_wr = 1'b0; ri_a = '0; ri_wdata = '0;
        tick(); tick(); tick();
        n_vec++; if (ri_ready !== 1'b0)   begin n_err++; $display("FAIL rst_ready: got %b exp 0", ri_ready); end
        n_vec++; if (ri_rvalid !== 1'b0)  begin n_err++; $display("FAIL rst_rvalid: got %b exp 0", ri_rvalid); end
        n_vec++; if (ri_rdata !== 8'h00)  begin n_err++; $display("FAIL rst_rdata: got %h exp 00", ri_rdata); end
        n_vec++; if (ri_starved !== 1'b0) begin n_err++; $display("FAIL rst_starved: got %b exp 0", ri_starved); end
        n_vec++; if (vram_dout !== 8'h00) begin n_err++; $display("FAIL rst_vram_dout: got %h exp 00", vram_dout); end
        n_vec++; if (vram_wr !== 1'b0 || pal_wr !== 1'b0) begin n_err++; $display("FAIL rst_strobes: got vram_wr=%b pal_wr=%b exp 0/0", vram_wr, pal_wr); end
        rst_n = 1'b1; #1;
        n_vec++; if (ri_ready !== 1'b0)   begin n_err++; $display("FAIL rel_ready_pre_edge: got %b exp 0", ri_ready); end
        tick();
        n_vec++; if (ri_ready !== 1'b1)   begin n_err++; $display("FAIL rel_ready_post_edge: got %b exp 1", ri_ready); end
        n_vec++; if (vram_a !== 14'h0123) begin n_err++; $display("FAIL idle_vram_a: got %h exp 0123", vram_a); end
    endtask

    task automatic test_vram_write();
        ri_valid = 1'b1; ri_wr = 1'b1; ri_a = 14'h2005; ri_wdata = 8'hA7; #1;
        n_vec++; if (vram_wr !== 1'b0) begin n_err++; $display("FAIL wr_empty_idle: got %b exp 0", vram_wr); end
        tick(); ri_valid = 1'b0; #1;
        n_vec++; if (vram_wr !== 1'b1)     begin n_err++; $display("FAIL wr_strobe: got %b exp 1", vram_wr); end
        n_vec++; if (vram_a !== 14'h2005)  begin n_err++; $display("FAIL wr_addr: got %h exp 2005", vram_a); end
        n_vec++; if (vram_dout !== 8'hA7)  begin n_err++; $display("FAIL wr_data: got %h exp A7", vram_dout); end
        n_vec++; if (pal_wr !== 1'b0)      begin n_err++; $display("FAIL wr_no_pal: got %b exp 0", pal_wr); end
        tick();
        n_vec++; if (vram_wr !== 1'b0)     begin n_err++; $display("FAIL wr_once: got %b exp 0", vram_wr); end
        n_vec++; if (vram_dout !== 8'hA7)  begin n_err++; $display("FAIL wr_dout_hold: got %h exp A7", vram_dout); end
        n_vec++; if (vram_a !== 14'h0123)  begin n_err++; $display("FAIL wr_bus_release: got %h exp 0123", vram_a); end
    endtask

    task automatic test_vram_read();
        ri_valid = 1'b1; ri_wr = 1'b0; ri_a = 14'h2005; #1;
        tick(); ri_valid = 1'b0; #1;
        n_vec++; if (vram_a !== 14'h2005 || vram_wr !== 1'b0) begin n_err++; $display("FAIL rd_issue: got a=%h wr=%b exp 2005/0", vram_a, vram_wr); end
        n_vec++; if (ri_rvalid !== 1'b0)  begin n_err++; $display("FAIL rd_lat0: got %b exp 0", ri_rvalid); end
        tick(); disp_req = 1'b1; #1;
        n_vec++; if (ri_rvalid !== 1'b0)  begin n_err++; $display("FAIL rd_lat1: got %b exp 0", ri_rvalid); end
        n_vec++; if (vram_a !== 14'h0123) begin n_err++; $display("FAIL rd_wait_disp: got %h exp 0123", vram_a); end
        tick(); disp_req = 1'b0; #1;
        n_vec++; if (ri_rvalid !== 1'b1)  begin n_err++; $display("FAIL rd_lat2_valid: got %b exp 1", ri_rvalid); end
        n_vec++; if (ri_rdata !== 8'hA7)  begin n_err++; $display("FAIL rd_data: got %h exp A7", ri_rdata); end
        tick();
        n_vec++; if (ri_rvalid !== 1'b0)  begin n_err++; $display("FAIL rd_pulse: got %b exp 0", ri_rvalid); end
        n_vec++; if (ri_rdata !== 8'hA7)  begin n_err++; $display("FAIL rd_hold: got %h exp A7", ri_rdata); end
    endtask

    task automatic test_palette();
        ri_valid = 1'b1; ri_wr = 1'b1; ri_a = 14'h3F10; ri_wdata = 8'h2C; #1;
        tick(); ri_wr = 1'b0; ri_a = 14'h3F00; ri_wdata = 8'h00; #1;
        n_vec++; if (pal_wr !== 1'b1 || pal_a !== 5'h00) begin n_err++; $display("FAIL pal_wr_mirror: got wr=%b a=%h exp 1/00", pal_wr, pal_a); end
        n_vec++; if (pal_dout !== 6'h2C)  begin n_err++; $display("FAIL pal_wdata: got %h exp 2C", pal_dout); end
        n_vec++; if (vram_wr !== 1'b0)    begin n_err++; $display("FAIL pal_no_vram: got %b exp 0", vram_wr); end
        tick(); ri_valid = 1'b0; #1;
        n_vec++; if (pal_wr !== 1'b0 || pal_a !== 5'h00) begin n_err++; $display("FAIL pal_rd_issue: got wr=%b a=%h exp 0/00", pal_wr, pal_a); end
        n_vec++; if (ri_rvalid !== 1'b0)  begin n_err++; $display("FAIL pal_rd_lat0: got %b exp 0", ri_rvalid); end
        tick();
        n_vec++; if (ri_rvalid !== 1'b1 || ri_rdata !== 8'h2C) begin n_err++; $display("FAIL pal_rd_lat1: got v=%b d=%h exp 1/2C", ri_rvalid, ri_rdata); end
        ri_valid = 1'b1; ri_wr = 1'b1; ri_a = 14'h3F1C; ri_wdata = 8'h15; #1;
        tick(); ri_a = 14'h3F11; ri_wdata = 8'h01; #1;
        n_vec++; if (pal_wr !== 1'b1 || pal_a !== 5'h0C) begin n_err++; $display("FAIL pal_1c_mirror: got wr=%b a=%h exp 1/0C", pal_wr, pal_a); end
        tick(); ri_valid = 1'b0; #1;
        n_vec++; if (pal_wr !== 1'b1 || pal_a !== 5'h11) begin n_err++; $display("FAIL pal_11_plain: got wr=%b a=%h exp 1/11", pal_wr, pal_a); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [22:0] cmds [5];
        cmds[0] = {1'b1, 14'h0100, 8'h11};
        cmds[1] = {1'b0, 14'h0100, 8'h00};
        cmds[2] = {1'b1, 14'h0101, 8'h22};
        cmds[3] = {1'b0, 14'h2005, 8'h00};
        cmds[4] = {1'b1, 14'h3F05, 8'h33};
        disp_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ri_valid = 1'b1; {ri_wr, ri_a, ri_wdata} = cmds[i]; #1;
            n_vec++; if (ri_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready[%0d]: got %b exp 1", i, ri_ready); end
            tick();
        end
        {ri_wr, ri_a, ri_wdata} = cmds[4]; #1;
        n_vec++; if (ri_ready !== 1'b0 || vram_wr !== 1'b0) begin n_err++; $display("FAIL b2b_full: got ready=%b wr=%b exp 0/0", ri_ready, vram_wr); end
        tick(); disp_req = 1'b0; #1;
        n_vec++; if (ri_ready !== 1'b0)  begin n_err++; $display("FAIL b2b_full_issue_ready: got %b exp 0", ri_ready); end
        n_vec++; if (vram_wr !== 1'b1 || vram_a !== 14'h0100 || vram_dout !== 8'h11) begin n_err++; $display("FAIL b2b_c0: got wr=%b a=%h d=%h exp 1/0100/11", vram_wr, vram_a, vram_dout); end
        tick();
        n_vec++; if (ri_ready !== 1'b1 || vram_wr !== 1'b0 || vram_a !== 14'h0100) begin n_err++; $display("FAIL b2b_c1: got ready=%b wr=%b a=%h exp 1/0/0100", ri_ready, vram_wr, vram_a); end
        tick(); ri_valid = 1'b0; #1;
        n_vec++; if (ri_rvalid !== 1'b0 || vram_wr !== 1'b0) begin n_err++; $display("FAIL b2b_rdwait1: got v=%b wr=%b exp 0/0", ri_rvalid, vram_wr); end
        tick();
        n_vec++; if (ri_rvalid !== 1'b1 || ri_rdata !== 8'h11) begin n_err++; $display("FAIL b2b_r1: got v=%b d=%h exp 1/11", ri_rvalid, ri_rdata); end
        n_vec++; if (vram_wr !== 1'b1 || vram_a !== 14'h0101 || vram_dout !== 8'h22) begin n_err++; $display("FAIL b2b_c2: got wr=%b a=%h d=%h exp 1/0101/22", vram_wr, vram_a, vram_dout); end
        tick();
        n_vec++; if (ri_rvalid !== 1'b0 || vram_a !== 14'h2005 || vram_wr !== 1'b0) begin n_err++; $display("FAIL b2b_c3: got v=%b a=%h wr=%b exp 0/2005/0", ri_rvalid, vram_a, vram_wr); end
        tick();
        n_vec++; if (pal_wr !== 1'b0 || vram_wr !== 1'b0) begin n_err++; $display("FAIL b2b_rdwait3: got pal_wr=%b wr=%b exp 0/0", pal_wr, vram_wr); end
        tick();
        n_vec++; if (ri_rvalid !== 1'b1 || ri_rdata !== 8'hA7) begin n_err++; $display("FAIL b2b_r3: got v=%b d=%h exp 1/A7", ri_rvalid, ri_rdata); end
        n_vec++; if (pal_wr !== 1'b1 || pal_a !== 5'h05 || pal_dout !== 6'h33) begin n_err++; $display("FAIL b2b_c4: got wr=%b a=%h d=%h exp 1/05/33", pal_wr, pal_a, pal_dout); end
        tick();
        n_vec++; if (pal_wr !== 1'b0 || ri_rvalid !== 1'b0 || ri_ready !== 1'b1) begin n_err++; $display("FAIL b2b_drained: got pal_wr=%b v=%b ready=%b exp 0/0/1", pal_wr, ri_rvalid, ri_ready); end
    endtask

    task automatic test_starve();
        disp_req = 1'b1;
        ri_valid = 1'b1; ri_wr = 1'b1; ri_a = 14'h0200; ri_wdata = 8'h55; #1;
        tick(); ri_valid = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (i == 31) begin
                n_vec++; if (ri_starved !== 1'b0) begin n_err++; $display("FAIL starve_31: got %b exp 0", ri_starved); end
            end
            if (i == 32) begin
                n_vec++; if (ri_starved !== 1'b1) begin n_err++; $display("FAIL starve_32: got %b exp 1", ri_starved); end
            end
        end
        n_vec++; if (ri_starved !== 1'b1 || vram_wr !== 1'b0) begin n_err++; $display("FAIL starve_40: got st=%b wr=%b exp 1/0", ri_starved, vram_wr); end
        disp_req = 1'b0; #1;
        n_vec++; if (vram_wr !== 1'b1 || vram_a !== 14'h0200 || vram_dout !== 8'h55) begin n_err++; $display("FAIL starve_issue: got wr=%b a=%h d=%h exp 1/0200/55", vram_wr, vram_a, vram_dout); end
        tick();
        n_vec++; if (ri_starved !== 1'b1) begin n_err++; $display("FAIL starve_sticky: got %b exp 1", ri_starved); end
    endtask

    task automatic test_reset_rd_wait();
        ri_valid = 1'b1; ri_wr = 1'b0; ri_a = 14'h2005; #1;
        tick(); ri_wr = 1'b1; ri_a = 14'h0300; ri_wdata = 8'h99; #1;
        n_vec++; if (vram_a !== 14'h2005) begin n_err++; $display("FAIL rr_issue: got %h exp 2005", vram_a); end
        tick(); ri_valid = 1'b0; #1;
        rst_n = 1'b0; #1;
        n_vec++; if (ri_rvalid !== 1'b0 || ri_rdata !== 8'h00) begin n_err++; $display("FAIL rr_resp: got v=%b d=%h exp 0/00", ri_rvalid, ri_rdata); end
        n_vec++; if (ri_ready !== 1'b0 || ri_starved !== 1'b0) begin n_err++; $display("FAIL rr_flags: got ready=%b st=%b exp 0/0", ri_ready, ri_starved); end
        n_vec++; if (vram_dout !== 8'h00 || vram_wr !== 1'b0 || pal_wr !== 1'b0) begin n_err++; $display("FAIL rr_bus: got d=%h wr=%b pwr=%b exp 00/0/0", vram_dout, vram_wr, pal_wr); end
        tick(); tick();
        n_vec++; if (ri_rvalid !== 1'b0) begin n_err++; $display("FAIL rr_no_rvalid: got %b exp 0", ri_rvalid); end
        rst_n = 1'b1; #1;
        n_vec++; if (ri_ready !== 1'b0 || vram_wr !== 1'b0) begin n_err++; $display("FAIL rr_release: got ready=%b wr=%b exp 0/0", ri_ready, vram_wr); end
        tick();
        n_vec++; if (ri_ready !== 1'b1 || vram_wr !== 1'b0 || ri_rvalid !== 1'b0 || vram_a !== 14'h0123) begin n_err++; $display("FAIL rr_empty: got ready=%b wr=%b v=%b a=%h exp 1/0/0/0123", ri_ready, vram_wr, ri_rvalid, vram_a); end
    endtask

    initial begin
        test_reset();
        test_vram_write();
        test_vram_read();
        test_palette();
        test_back_to_back();
        test_starve();
        test_reset_rd_wait();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
